// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Receiver states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 5208;

  // 2-of-3 vote used by the majority sampling build.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the asynchronous rx pin, plus a
//               previous-value flop giving a falling-edge strobe. All flops
//               reset to 1 (line idle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resolve metastability over two flops, then keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx   = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, fixed baud from CLKS_PER_BIT.
//               Samples each bit at its centre and presents the byte with a
//               one-cycle valid strobe; a low stop bit gives a one-cycle
//               frame_err strobe and the byte is dropped.
//               Optional macro UART_RX_MAJORITY_EN: each sample becomes a
//               2-of-3 vote over the last three synchronised values, decided
//               on the same cycle as the single-sample build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_half  = CLKS_PER_BIT / 2;

  // Terminal counts: start sample sits half a bit in, the rest a full bit apart.
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         c_idx_last  = 3'(UART_DATA_BITS - 1);

  logic w_rx;
  logic w_fall;
  logic w_bit;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (rx),
    .o_rx   (w_rx),
    .o_fall (w_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // Keep the two previous synchronised values so the vote lands on the target count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx};
    end
  end

  assign w_bit = maj3(r_hist[1], r_hist[0], w_rx);
`else
  assign w_bit = w_rx;
`endif

  uart_rx_state_t            r_state;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [2:0]                r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_frame_err;
  logic                      r_busy;

  // Frame sequencer: start qualification, data shift-in, stop check, strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == c_half_last) begin
            if (w_bit) begin
              // Line back high at mid start bit: treat as a glitch.
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == c_bit_last) begin
            r_cnt   <= '0;
            r_shift <= {w_bit, r_shift[UART_DATA_BITS-1:1]};
            if (r_idx == c_idx_last) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == c_bit_last) begin
            // Back to IDLE at the stop centre so an immediate next start is seen.
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
            if (w_bit) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Bench for uart_rx. The whole rx/rst_n waveform is planned up
//               front; a frame-level model derives the expected outputs for
//               every cycle from bit-centre positions, and literal values pin
//               the directed frames. Honours UART_RX_MAJORITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Planned stimulus, one entry per cycle; rst_plan=1 means reset asserted.
  bit         pin_plan [MAXC];
  bit         rst_plan [MAXC];
  bit         exp_valid[MAXC];
  bit         exp_ferr [MAXC];
  bit         exp_busy [MAXC];
  logic [7:0] exp_data [MAXC];
  bit         chg      [MAXC];
  logic [7:0] chg_val  [MAXC];

  typedef struct {
    int         cyc;
    bit         v;
    bit         f;
    bit         b;
    logic [7:0] d;
    string      nm;
  } lit_t;
  lit_t lits[$];

  int wp;
  int end_c;
  int cyc;
  int n_vec = 0;
  int n_err = 0;

  task automatic put(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      pin_plan[wp] = v;
      wp++;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop, output int p);
    p = wp;
    put(1'b0, CPB);
    for (int k = 0; k < 8; k++) put(b[k], CPB);
    put(stop, CPB);
  endtask

  // Cycle at which valid/frame_err should appear for a start bit driven at pin cycle p.
  function automatic int pulse_at(input int p);
    return p + 3 + HALF + 9 * CPB;
  endfunction

  function automatic bit samp(input int s);
`ifdef UART_RX_MAJORITY_EN
    int n;
    n = int'(pin_plan[s-2]) + int'(pin_plan[s-1]) + int'(pin_plan[s]);
    return n >= 2;
`else
    return pin_plan[s];
`endif
  endfunction

  function automatic bit eff(input int c);
    return rst_plan[c] ? 1'b1 : pin_plan[c];
  endfunction

  task automatic add_lit(input int c, input bit v, input bit f, input bit b,
                         input logic [7:0] d, input string nm);
    lit_t l;
    l.cyc = c; l.v = v; l.f = f; l.b = b; l.d = d; l.nm = nm;
    lits.push_back(l);
  endtask

  // Frame-level reference: pin edge -> bit-centre samples -> outputs per cycle.
  task automatic build_model();
    int         c;
    int         idle_at;
    int         p;
    int         last;
    int         ra;
    bit         glitch;
    logic [7:0] b;
    logic [7:0] d;
    for (int i = 0; i < MAXC; i++) begin
      exp_valid[i] = 1'b0; exp_ferr[i] = 1'b0; exp_busy[i] = 1'b0; chg[i] = 1'b0;
    end
    c = 1;
    idle_at = 0;
    while (c < end_c) begin
      if (eff(c-1) && !eff(c) && (c + 2 >= idle_at) &&
          !rst_plan[c] && !rst_plan[c+1] && !rst_plan[c+2] &&
          (pulse_at(c) < MAXC)) begin
        p      = c;
        glitch = samp(p + HALF);
        last   = glitch ? p + 2 + HALF : pulse_at(p);
        ra     = -1;
        for (int x = p + 3; x <= last; x++) if (rst_plan[x] && ra < 0) ra = x;
        if (ra >= 0) begin
          for (int x = p + 3; x < ra; x++) exp_busy[x] = 1'b1;
          idle_at = ra;
        end else if (glitch) begin
          for (int x = p + 3; x <= last; x++) exp_busy[x] = 1'b1;
          idle_at = last + 1;
        end else begin
          for (int k = 0; k < 8; k++) b[k] = samp(p + HALF + (k + 1) * CPB);
          for (int x = p + 3; x < last; x++) exp_busy[x] = 1'b1;
          if (samp(p + HALF + 9 * CPB)) begin
            exp_valid[last] = 1'b1;
            chg[last]       = 1'b1;
            chg_val[last]   = b;
          end else begin
            exp_ferr[last] = 1'b1;
          end
          idle_at = last;
        end
        c = p + 1;
      end else begin
        c++;
      end
    end
    d = 8'h00;
    for (int i = 0; i < MAXC; i++) begin
      if (rst_plan[i]) d = 8'h00;
      else if (chg[i]) d = chg_val[i];
      exp_data[i] = d;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, got, expv);
    end
  endtask

  // Compare process: every cycle against the model, plus literal pins.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < end_c) begin
        chk("valid",     {7'd0, valid},     {7'd0, exp_valid[cyc]});
        chk("frame_err", {7'd0, frame_err}, {7'd0, exp_ferr[cyc]});
        chk("busy",      {7'd0, busy},      {7'd0, exp_busy[cyc]});
        chk("data",      data,              exp_data[cyc]);
        while (lits.size() > 0 && lits[0].cyc == cyc) begin
          chk({lits[0].nm, ".valid"}, {7'd0, valid},     {7'd0, lits[0].v});
          chk({lits[0].nm, ".ferr"},  {7'd0, frame_err}, {7'd0, lits[0].f});
          chk({lits[0].nm, ".busy"},  {7'd0, busy},      {7'd0, lits[0].b});
          chk({lits[0].nm, ".data"},  data,              lits[0].d);
          chk({lits[0].nm, ".model_valid"}, {7'd0, exp_valid[cyc]}, {7'd0, lits[0].v});
          chk({lits[0].nm, ".model_data"},  exp_data[cyc],          lits[0].d);
          void'(lits.pop_front());
        end
      end
    end
  end

  initial begin
    int         p;
    int         pa5, p00, pff, p3c, p55, p12, pg, p81, p7e, pf0;
    int         ra;
    int         gap;
    bit         stop;
    logic [7:0] rb;
    logic [7:0] f0_exp;

    for (int i = 0; i < MAXC; i++) begin
      pin_plan[i] = 1'b1;
      rst_plan[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) rst_plan[i] = 1'b1;
    wp = 10;

    // Single frame.
    put(1'b1, 20);
    send(8'hA5, 1'b1, pa5);
    // Back-to-back frames.
    send(8'h00, 1'b1, p00);
    send(8'hFF, 1'b1, pff);
    send(8'h3C, 1'b1, p3c);
    // Bad stop bit, line held low, then a good frame.
    put(1'b1, 20);
    send(8'h55, 1'b0, p55);
    put(1'b0, 3 * CPB);
    put(1'b1, 20);
    send(8'h12, 1'b1, p12);
    // Short low pulse.
    put(1'b1, 20);
    pg = wp;
    put(1'b0, 4);
    put(1'b1, 40);
    // Reset during bit 3, released while the line is high in bit 7.
    send(8'h81, 1'b1, p81);
    ra = p81 + 4 * CPB + 4;
    for (int i = ra; i < p81 + 8 * CPB + 8; i++) rst_plan[i] = 1'b1;
    put(1'b1, 20);
    send(8'h7E, 1'b1, p7e);
    // One-cycle inverting glitch at the centre of bit 2.
    put(1'b1, 20);
    send(8'hF0, 1'b1, pf0);
    pin_plan[pf0 + HALF + 3 * CPB] = ~pin_plan[pf0 + HALF + 3 * CPB];
`ifdef UART_RX_MAJORITY_EN
    f0_exp = 8'hF0;
`else
    f0_exp = 8'hF4;
`endif
    // Randomised frames with random gaps, bad stops and glitches.
    for (int n = 0; n < 25; n++) begin
      gap = $urandom_range(0, 40);
      put(1'b1, gap);
      rb   = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send(rb, stop, p);
      if ($urandom_range(0, 3) == 0) begin
        gap = p + CPB + $urandom_range(0, 8 * CPB - 1);
        pin_plan[gap] = ~pin_plan[gap];
      end
      if (!stop) put(1'b1, 2);
    end
    put(1'b1, 300);
    end_c = wp;

    build_model();

    add_lit(2,                    0, 0, 0, 8'h00, "reset_state");
    add_lit(pa5 + 3,              0, 0, 1, 8'h00, "a5_busy");
    add_lit(pulse_at(pa5),        1, 0, 0, 8'hA5, "a5_rx");
    add_lit(pulse_at(p00),        1, 0, 0, 8'h00, "b2b_00");
    add_lit(pulse_at(pff),        1, 0, 0, 8'hFF, "b2b_ff");
    add_lit(pulse_at(p3c),        1, 0, 0, 8'h3C, "b2b_3c");
    add_lit(pulse_at(p55),        0, 1, 0, 8'h3C, "55_frame_err");
    add_lit(pulse_at(p12),        1, 0, 0, 8'h12, "12_rx");
    add_lit(pg + 3,               0, 0, 1, 8'h12, "glitch_busy");
    add_lit(pg + 11,              0, 0, 0, 8'h12, "glitch_idle");
    add_lit(ra - 1,               0, 0, 1, 8'h12, "81_busy");
    add_lit(ra,                   0, 0, 0, 8'h00, "81_reset");
    add_lit(pulse_at(p7e),        1, 0, 0, 8'h7E, "7e_rx");
    add_lit(pulse_at(pf0),        1, 0, 0, f0_exp, "f0_glitch");

    cyc   = 0;
    rst_n = ~rst_plan[0];
    rx    = pin_plan[0];
    while (cyc < end_c) begin
      @(posedge clk);
      cyc++;
      #1;
      rst_n = ~rst_plan[cyc];
      rx    = pin_plan[cyc];
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (lits.size() != 0) begin
      n_err++;
      $display("FAIL literal_queue: %0d entries unchecked, expected 0", lits.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
